// File: rtl/sc_screen_pkg.sv
// Shared definitions for the 8x8 screen sequencer: state codes, screen bitmaps, level lookup.
// Frames pack row k into bits [8k+7:8k], row 7 at the top of the matrix.
package sc_screen_pkg;

    localparam int DATAWIDTH_BUS = 8;
    localparam int FRAME_W       = 8 * DATAWIDTH_BUS;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_GO         = 3'd1,
        ST_LEVEL      = 3'd2,
        ST_PLAY       = 3'd3,
        ST_OVER_SHOW  = 3'd4,
        ST_OVER_BLANK = 3'd5
    } state_e;

    localparam logic [FRAME_W-1:0] SCR_START = 64'h0066_6600_8142_3C00;
    localparam logic [FRAME_W-1:0] SCR_GO    = 64'h00EE_89AB_A9EE_0000;
    localparam logic [FRAME_W-1:0] SCR_L1    = 64'h0018_1818_1818_3C00;
    localparam logic [FRAME_W-1:0] SCR_L2    = 64'h003C_0C0C_3830_3C00;
    localparam logic [FRAME_W-1:0] SCR_L3    = 64'h3C06_1C06_063C_0018;
    localparam logic [FRAME_W-1:0] SCR_VM    = 64'h0F09_0F00_0090_F0F0;
    localparam logic [FRAME_W-1:0] SCR_MV    = 64'hF090_F000_0009_0F0F;

    // A latched level of 0 can only exist straight out of reset; it shows as level 1.
    function automatic logic [FRAME_W-1:0] level_screen(input logic [1:0] lvl);
        case (lvl)
            2'd2:    return SCR_L2;
            2'd3:    return SCR_L3;
            default: return SCR_L1;
        endcase
    endfunction

endpackage

// File: rtl/sc_tick_prescaler.sv
// Free-running prescaler: tick_o is high while the count is all ones, then the count wraps.
// clr_i restarts the count at 0 on the next clock; no backpressure.
module sc_tick_prescaler #(
    parameter int WIDTH = 23
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = &cnt_q;

endmodule

// File: rtl/sc_screen_sequencer.sv
// Splash/play/game-over frame source for the 8x8 matrix; outputs registered one clock after the state.
// No backpressure: the matrix controller samples frame_Out continuously.
module sc_screen_sequencer
    import sc_screen_pkg::*;
#(
    parameter int PRESCALER_DATAWIDTH = 23,
    parameter int HOLD_TICKS          = 4,
    parameter int BLINK_TICKS         = 2
) (
    input  logic               SC_SCREENSEQ_CLOCK_50,
    input  logic               SC_SCREENSEQ_RESET_InHigh,
    input  logic               SC_SCREENSEQ_start_In,
    input  logic [1:0]         SC_SCREENSEQ_level_In,
    input  logic               SC_SCREENSEQ_gameOver_In,
    input  logic               SC_SCREENSEQ_winner_In,
    input  logic [FRAME_W-1:0] SC_SCREENSEQ_gameFrame_In,
    output logic [FRAME_W-1:0] SC_SCREENSEQ_frame_Out,
    output logic               SC_SCREENSEQ_play_Out,
    output logic [2:0]         SC_SCREENSEQ_state_Out
);

    state_e             state_q, state_d;
    logic               start_q;
    logic [1:0]         level_q, level_d;
    logic               winner_q, winner_d;
    logic [3:0]         tick_cnt_q, tick_cnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               play_q, play_d;
    logic [2:0]         state_out_q;

    logic start_edge;
    logic tick;
    logic state_chg;
    logic hold_done;
    logic blink_done;
    logic [1:0] level_sel;

    assign start_edge = SC_SCREENSEQ_start_In & ~start_q;
    assign level_sel  = (SC_SCREENSEQ_level_In == 2'd0) ? 2'd1 : SC_SCREENSEQ_level_In;
    assign hold_done  = tick && (tick_cnt_q == 4'(HOLD_TICKS - 1));
    assign blink_done = tick && (tick_cnt_q == 4'(BLINK_TICKS - 1));
    assign state_chg  = (state_d != state_q);

    sc_tick_prescaler #(
        .WIDTH (PRESCALER_DATAWIDTH)
    ) u_prescaler (
        .clk_i  (SC_SCREENSEQ_CLOCK_50),
        .rst_i  (SC_SCREENSEQ_RESET_InHigh),
        .clr_i  (state_chg),
        .tick_o (tick)
    );

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        winner_d = winner_q;
        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d = ST_GO;
                    level_d = level_sel;
                end
            end
            ST_GO: begin
                if (hold_done) state_d = ST_LEVEL;
            end
            ST_LEVEL: begin
                if (hold_done) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                // Start is never looked at here, so gameOver wins any collision.
                if (SC_SCREENSEQ_gameOver_In) begin
                    state_d  = ST_OVER_SHOW;
                    winner_d = SC_SCREENSEQ_winner_In;
                end
            end
            ST_OVER_SHOW: begin
                if (start_edge) begin
                    state_d = ST_GO;
                    level_d = level_sel;
                end else if (blink_done) begin
                    state_d = ST_OVER_BLANK;
                end
            end
            ST_OVER_BLANK: begin
                if (start_edge) begin
                    state_d = ST_GO;
                    level_d = level_sel;
                end else if (blink_done) begin
                    state_d = ST_OVER_SHOW;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (state_chg) begin
            tick_cnt_d = 4'd0;
        end else if (tick) begin
            tick_cnt_d = tick_cnt_q + 4'd1;
        end
    end

    always_comb begin
        frame_d = SCR_START;
        play_d  = 1'b0;
        case (state_q)
            ST_IDLE:       frame_d = SCR_START;
            ST_GO:         frame_d = SCR_GO;
            ST_LEVEL:      frame_d = level_screen(level_q);
            ST_PLAY: begin
                frame_d = SC_SCREENSEQ_gameFrame_In;
                play_d  = 1'b1;
            end
            ST_OVER_SHOW:  frame_d = winner_q ? SCR_MV : SCR_VM;
            ST_OVER_BLANK: frame_d = '0;
            default:       frame_d = SCR_START;
        endcase
    end

    always_ff @(posedge SC_SCREENSEQ_CLOCK_50) begin
        if (SC_SCREENSEQ_RESET_InHigh) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            level_q     <= 2'd0;
            winner_q    <= 1'b0;
            tick_cnt_q  <= 4'd0;
            frame_q     <= SCR_START;
            play_q      <= 1'b0;
            state_out_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            start_q     <= SC_SCREENSEQ_start_In;
            level_q     <= level_d;
            winner_q    <= winner_d;
            tick_cnt_q  <= tick_cnt_d;
            frame_q     <= frame_d;
            play_q      <= play_d;
            state_out_q <= state_q;
        end
    end

    assign SC_SCREENSEQ_frame_Out = frame_q;
    assign SC_SCREENSEQ_play_Out  = play_q;
    assign SC_SCREENSEQ_state_Out = state_out_q;

endmodule

// File: tb/tb_sc_screen_sequencer.sv
// Directed bench for sc_screen_sequencer with a 16-clock tick, 2-tick hold and 1-tick blink.
module tb_sc_screen_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  level;
    logic        game_over;
    logic        winner;
    logic [63:0] game_frame;
    logic [63:0] frame;
    logic        play;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;
    int play_bad;

    always #5 clk = ~clk;

    sc_screen_sequencer #(
        .PRESCALER_DATAWIDTH (4),
        .HOLD_TICKS          (2),
        .BLINK_TICKS         (1)
    ) dut (
        .SC_SCREENSEQ_CLOCK_50     (clk),
        .SC_SCREENSEQ_RESET_InHigh (rst),
        .SC_SCREENSEQ_start_In     (start),
        .SC_SCREENSEQ_level_In     (level),
        .SC_SCREENSEQ_gameOver_In  (game_over),
        .SC_SCREENSEQ_winner_In    (winner),
        .SC_SCREENSEQ_gameFrame_In (game_frame),
        .SC_SCREENSEQ_frame_Out    (frame),
        .SC_SCREENSEQ_play_Out     (play),
        .SC_SCREENSEQ_state_Out    (state)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] row(input logic [63:0] f, input int k);
        return f[8*k +: 8];
    endfunction

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        level      = 2'd0;
        game_over  = 1'b0;
        winner     = 1'b0;
        game_frame = 64'h0;
        step(2);
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_frame", frame, 64'h0066_6600_8142_3C00);
        chk("reset_play",  64'(play), 64'd0);
        rst = 1'b0;

        play_bad = 0;
        for (int k = 1; k <= 50; k++) begin
            step(1);
            if (state !== 3'd0 || play !== 1'b0 || row(frame, 6) !== 8'h66) play_bad++;
        end
        chk("idle_50_clocks", 64'(play_bad), 64'd0);

        // Start held for 100 clocks, level 0 -> level 1.
        start = 1'b1;
        level = 2'd0;
        play_bad = 0;
        for (int k = 1; k <= 100; k++) begin
            step(1);
            if (k < 66 && play !== 1'b0) play_bad++;
            if (k == 1)  chk("start_edge_lat", 64'(state), 64'd0);
            if (k == 2) begin
                chk("go_enter",  64'(state), 64'd1);
                chk("go_row5",   64'(row(frame, 5)), 64'h89);
            end
            if (k == 33) chk("go_last",   64'(state), 64'd1);
            if (k == 34) begin
                chk("lvl1_enter", 64'(state), 64'd2);
                chk("lvl1_row5",  64'(row(frame, 5)), 64'h18);
            end
            if (k == 65) chk("lvl1_last", 64'(state), 64'd2);
            if (k == 66) begin
                chk("play_enter", 64'(state), 64'd3);
                chk("play_out",   64'(play), 64'd1);
                chk("play_frame0", frame, 64'h0);
            end
            if (k == 70) game_frame = 64'h0123_4567_89AB_CDEF;
            if (k == 71) chk("play_passthru", frame, 64'h0123_4567_89AB_CDEF);
            if (k == 100) chk("held_no_retrig", 64'(state), 64'd3);
        end
        chk("play_low_before_play", 64'(play_bad), 64'd0);
        start = 1'b0;
        step(2);

        // Game over, right player alive: MV screen blinking with 16-clock halves.
        game_over = 1'b1;
        winner    = 1'b1;
        level     = 2'd3;
        for (int j = 1; j <= 85; j++) begin
            step(1);
            if (j == 1) begin
                game_over = 1'b0;
                chk("over_lat", 64'(state), 64'd3);
            end
            if (j == 2) begin
                chk("over_show",  64'(state), 64'd4);
                chk("over_play",  64'(play), 64'd0);
                chk("over_row7",  64'(row(frame, 7)), 64'hF0);
            end
            if (j == 17) chk("show_last", 64'(state), 64'd4);
            if (j == 18) begin
                chk("blank_enter", 64'(state), 64'd5);
                chk("blank_frame", frame, 64'h0);
            end
            if (j == 33) chk("blank_last", 64'(state), 64'd5);
            if (j == 34) begin
                chk("reshow_state", 64'(state), 64'd4);
                chk("reshow_row7",  64'(row(frame, 7)), 64'hF0);
            end
            if (j == 40) start = 1'b1;
            if (j == 41) chk("restart_lat", 64'(state), 64'd4);
            if (j == 42) begin
                chk("restart_go", 64'(state), 64'd1);
                chk("restart_go_row5", 64'(row(frame, 5)), 64'h89);
            end
            if (j == 50) start = 1'b0;
            if (j == 74) begin
                chk("lvl3_enter", 64'(state), 64'd2);
                chk("lvl3_row0",  64'(row(frame, 0)), 64'h18);
            end
            if (j == 80) rst = 1'b1;
            if (j == 81) begin
                chk("midlvl_rst_state", 64'(state), 64'd0);
                chk("midlvl_rst_frame", frame, 64'h0066_6600_8142_3C00);
                chk("midlvl_rst_play",  64'(play), 64'd0);
                rst = 1'b0;
            end
        end

        // Level 2, then gameOver and a start edge in the same PLAY cycle.
        start = 1'b1;
        level = 2'd2;
        for (int m = 1; m <= 70; m++) begin
            step(1);
            if (m == 2)  chk("lvl2_go", 64'(state), 64'd1);
            if (m == 34) chk("lvl2_row5", 64'(row(frame, 5)), 64'h0C);
            if (m == 66) begin
                chk("lvl2_play", 64'(state), 64'd3);
                start = 1'b0;
            end
            if (m == 67) begin
                start     = 1'b1;
                game_over = 1'b1;
                winner    = 1'b0;
            end
            if (m == 68) begin
                chk("collide_lat", 64'(state), 64'd3);
                game_over = 1'b0;
            end
            if (m == 69) begin
                chk("collide_over", 64'(state), 64'd4);
                chk("collide_vm_row7", 64'(row(frame, 7)), 64'h0F);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
